// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache.
// Misses write back a dirty victim, then refill the line and re-evaluate the held request.
module dcache_wb #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_rw,
    input  logic [31:0]             din,
    output logic                    is_ready,
    output logic                    is_output_valid,
    output logic [31:0]             dout,
    output logic                    is_hit,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [31:0]             mem_req_addr,
    output logic [32*LINE_WORDS-1:0] mem_req_data,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [32*LINE_WORDS-1:0] mem_resp_data
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int OB = 2 + WB;
    localparam int IB = $clog2(NUM_SETS);
    localparam int TW = 32 - OB - IB;
    localparam int LB = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOC_REQ, ALLOC_WAIT} state_t;

    state_t                       state_q, state_d;
    logic [NUM_SETS-1:0]          valid_q, valid_d, dirty_q, dirty_d;
    logic [NUM_SETS-1:0][TW-1:0]  tag_q, tag_d;
    logic [NUM_SETS-1:0][LB-1:0]  data_q, data_d;

    logic [WB-1:0] off;
    logic [IB-1:0] idx;
    logic [TW-1:0] tag;
    logic          unused_addr_lsb;

    assign off             = addr[OB-1:2];
    assign idx             = addr[OB+IB-1:OB];
    assign tag             = addr[31:OB+IB];
    assign unused_addr_lsb = ^addr[1:0];

    assign is_hit          = valid_q[idx] && tag_q[idx] == tag;
    assign is_ready        = state_q == IDLE;
    assign is_output_valid = is_ready && is_input_valid && is_hit;
    assign dout            = is_output_valid && !mem_rw ? data_q[idx][{off, 5'b0} +: 32] : '0;
    assign mem_req_valid   = state_q == WRITEBACK || state_q == ALLOC_REQ;
    assign mem_req_write   = state_q == WRITEBACK;
    assign mem_req_addr    = mem_req_write ? {tag_q[idx], idx, {OB{1'b0}}} :
                             state_q == ALLOC_REQ ? {tag, idx, {OB{1'b0}}} : '0;
    assign mem_req_data    = mem_req_write ? data_q[idx] : '0;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (is_output_valid && mem_rw) begin
                    data_d[idx][{off, 5'b0} +: 32] = din;
                    dirty_d[idx] = 1'b1;
                end else if (is_input_valid && !is_hit) begin
                    state_d = valid_q[idx] && dirty_q[idx] ? WRITEBACK : ALLOC_REQ;
                end
            end
            WRITEBACK: state_d = mem_req_ready ? ALLOC_REQ : WRITEBACK;
            ALLOC_REQ: state_d = mem_req_ready ? ALLOC_WAIT : ALLOC_REQ;
            ALLOC_WAIT: begin
                // The refill lands clean; a pending store dirties it on the following IDLE hit.
                if (mem_resp_valid) begin
                    data_d[idx]  = mem_resp_data;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed and randomized checks of dcache_wb against a word-level memory
// image and a per-set valid/dirty/tag reference model.
module tb_dcache_wb;
    localparam int LW = 4;
    localparam int LB = 32 * LW;

    logic          clk = 1'b0;
    logic          reset, is_input_valid, mem_rw;
    logic [31:0]   addr, din;
    logic          is_ready, is_output_valid, is_hit;
    logic [31:0]   dout;
    logic          mem_req_valid, mem_req_write;
    logic [31:0]   mem_req_addr;
    logic [LB-1:0] mem_req_data;
    logic          mem_req_ready, mem_resp_valid;
    logic [LB-1:0] mem_resp_data;

    always #5 clk = ~clk;

    dcache_wb #(.LINE_WORDS(LW), .NUM_SETS(16)) dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_rw(mem_rw), .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid),
        .dout(dout), .is_hit(is_hit), .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    int vectors = 0;
    int miscompares = 0;

    // shadow: what a load must return; mem_img: what the backing memory currently holds
    logic [31:0] shadow [int unsigned];
    logic [31:0] mem_img [int unsigned];
    bit ref_valid [16];
    bit ref_dirty [16];
    int ref_tag [16];

    logic [31:0]   last_wb_addr, last_rd_addr, last_dout;
    logic [LB-1:0] last_wb_data;
    int            last_nwb, last_nrd;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    function automatic logic [31:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_img.exists(a) ? mem_img[a] : init_word(a);
    endfunction

    function automatic logic [LB-1:0] sh_line(input logic [31:0] base);
        logic [LB-1:0] l;
        for (int i = 0; i < LW; i++) l[32*i +: 32] = sh_rd(base + 32'(4 * i));
        return l;
    endfunction

    function automatic logic [LB-1:0] mem_line(input logic [31:0] base);
        logic [LB-1:0] l;
        for (int i = 0; i < LW; i++) l[32*i +: 32] = mem_rd(base + 32'(4 * i));
        return l;
    endfunction

    // Presents one request and plays the memory side until completion; checks against the model.
    task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] d,
                          input int rdy_dly, input int resp_dly);
        int s, t, exp_lat, lat, wt, rwt;
        bit hit_exp, wb_exp, open, pend, done, got_hit;
        logic [31:0] vb, cap_addr;
        logic cap_w;
        logic [LB-1:0] cap_data;
        s = int'(a[7:4]);
        t = int'(a[31:8]);
        hit_exp = ref_valid[s] && ref_tag[s] == t;
        wb_exp = !hit_exp && ref_valid[s] && ref_dirty[s];
        vb = (32'(ref_tag[s]) << 8) | {24'h0, a[7:4], 4'h0};
        exp_lat = hit_exp ? 0 : 3 + rdy_dly + resp_dly + (wb_exp ? 1 + rdy_dly : 0);
        open = 0; pend = 0; done = 0; wt = 0; rwt = 0; lat = -1; got_hit = 0;
        last_nwb = 0; last_nrd = 0; last_dout = 'x;
        is_input_valid = 1; addr = a; mem_rw = rw; din = d;
        for (int c = 0; c < 100 && !done; c++) begin
            mem_req_ready = 0; mem_resp_valid = 0;
            #1;
            if (c == 0) begin
                vectors++;
                if (is_hit !== hit_exp) begin
                    miscompares++;
                    $display("FAIL lookup_hit addr=%h got %b want %b", a, is_hit, hit_exp);
                end
            end
            if (mem_req_valid) begin
                if (!open) begin
                    open = 1; wt = 0;
                    cap_addr = mem_req_addr; cap_w = mem_req_write; cap_data = mem_req_data;
                end else begin
                    vectors++;
                    if (mem_req_addr !== cap_addr || mem_req_write !== cap_w || mem_req_data !== cap_data) begin
                        miscompares++;
                        $display("FAIL req_stable cyc=%0d got addr=%h w=%b want addr=%h w=%b",
                                 c, mem_req_addr, mem_req_write, cap_addr, cap_w);
                    end
                end
                if (wt == rdy_dly) begin
                    mem_req_ready = 1; open = 0;
                    if (cap_w) begin
                        last_nwb++; last_wb_addr = cap_addr; last_wb_data = cap_data;
                        for (int i = 0; i < LW; i++) mem_img[cap_addr + 32'(4 * i)] = cap_data[32*i +: 32];
                    end else begin
                        last_nrd++; last_rd_addr = cap_addr; pend = 1; rwt = 0;
                    end
                end else wt++;
            end else if (pend) begin
                if (rwt == resp_dly) begin
                    mem_resp_valid = 1; mem_resp_data = mem_line(last_rd_addr); pend = 0;
                end else rwt++;
            end
            #1;
            if (is_output_valid) begin
                done = 1; lat = c; last_dout = dout; got_hit = is_hit;
            end else if (c > 0) begin
                vectors++;
                if (is_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_ready cyc=%0d got %b want 0", c, is_ready);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        is_input_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout addr=%h no completion within 100 cycles", a);
        end
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL latency addr=%h got %0d want %0d", a, lat, exp_lat);
        end
        vectors++;
        if (got_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL done_hit addr=%h got %b want 1", a, got_hit);
        end
        vectors++;
        if (last_dout !== (rw ? 32'h0 : sh_rd(a))) begin
            miscompares++;
            $display("FAIL dout addr=%h got %h want %h", a, last_dout, rw ? 32'h0 : sh_rd(a));
        end
        vectors++;
        if (last_nwb != int'(wb_exp) || last_nrd != int'(!hit_exp)) begin
            miscompares++;
            $display("FAIL traffic addr=%h got wb=%0d rd=%0d want wb=%0d rd=%0d",
                     a, last_nwb, last_nrd, wb_exp, !hit_exp);
        end
        if (wb_exp && last_nwb == 1) begin
            vectors++;
            if (last_wb_addr !== vb || last_wb_data !== sh_line(vb)) begin
                miscompares++;
                $display("FAIL wb_line got %h:%h want %h:%h", last_wb_addr, last_wb_data, vb, sh_line(vb));
            end
        end
        if (!hit_exp && last_nrd == 1) begin
            vectors++;
            if (last_rd_addr !== {a[31:4], 4'h0}) begin
                miscompares++;
                $display("FAIL rd_addr got %h want %h", last_rd_addr, {a[31:4], 4'h0});
            end
        end
        if (!hit_exp) begin
            ref_valid[s] = 1; ref_tag[s] = t; ref_dirty[s] = 0;
        end
        if (rw) begin
            shadow[a] = d; ref_dirty[s] = 1;
        end
    endtask

    task automatic test_reset;
        reset = 1; is_input_valid = 0; addr = 0; mem_rw = 0; din = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        vectors++;
        if ({is_ready, is_output_valid, is_hit, mem_req_valid, mem_req_write} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 10000",
                     {is_ready, is_output_valid, is_hit, mem_req_valid, mem_req_write});
        end
        vectors++;
        if (dout !== 0 || mem_req_addr !== 0 || mem_req_data !== '0) begin
            miscompares++;
            $display("FAIL reset_buses got dout=%h addr=%h want 0", dout, mem_req_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_cold_load;
        logic [31:0] w [4];
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            mem_img[32'h100 + 32'(4 * i)] = w[i];
            shadow[32'h100 + 32'(4 * i)] = w[i];
        end
        do_req(32'h100, 0, 0, 0, 2);
        vectors++;
        if (last_dout !== 32'h11 || last_nrd != 1 || last_rd_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL cold_load got dout=%h rd=%0d@%h want 11 1@100", last_dout, last_nrd, last_rd_addr);
        end
        do_req(32'h104, 0, 0, 0, 0);
        do_req(32'h10C, 0, 0, 0, 0);
        vectors++;
        if (last_dout !== 32'h44) begin
            miscompares++;
            $display("FAIL hit_10c got %h want 44", last_dout);
        end
    endtask

    task automatic test_store_hit;
        do_req(32'h108, 1, 32'hDEADBEEF, 0, 0);
        do_req(32'h108, 0, 0, 0, 0);
        vectors++;
        if (last_dout !== 32'hDEADBEEF || last_nrd + last_nwb != 0) begin
            miscompares++;
            $display("FAIL store_hit got %h req=%0d want deadbeef 0", last_dout, last_nrd + last_nwb);
        end
    endtask

    task automatic test_dirty_evict;
        logic [LB-1:0] want;
        want = {32'h44, 32'hDEADBEEF, 32'h22, 32'h11};
        do_req(32'h200, 0, 0, 1, 1);
        vectors++;
        if (last_wb_addr !== 32'h100 || last_wb_data !== want || last_rd_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL dirty_evict got wb %h:%h rd %h want wb 100:%h rd 200",
                     last_wb_addr, last_wb_data, last_rd_addr, want);
        end
    endtask

    task automatic test_store_miss;
        do_req(32'h300, 1, 32'hCAFE0001, 0, 1);
        do_req(32'h100, 0, 0, 0, 0);
        vectors++;
        if (last_nwb != 1 || last_wb_addr !== 32'h300 || last_wb_data[31:0] !== 32'hCAFE0001) begin
            miscompares++;
            $display("FAIL store_miss_dirty got wb=%0d@%h w0=%h want 1@300 cafe0001",
                     last_nwb, last_wb_addr, last_wb_data[31:0]);
        end
    endtask

    task automatic test_ready_stall;
        do_req(32'h500, 0, 0, 5, 1);
    endtask

    task automatic test_reset_mid_miss;
        bit got;
        logic [31:0] b;
        got = 0;
        is_input_valid = 1; addr = 32'h600; mem_rw = 0; din = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            mem_req_ready = 0;
            #1;
            if (mem_req_valid) begin
                mem_req_ready = 1;
                if (mem_req_write) begin
                    for (int i = 0; i < LW; i++) mem_img[mem_req_addr + 32'(4 * i)] = mem_req_data[32*i +: 32];
                    ref_dirty[0] = 0;
                end else got = 1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_req_ready = 0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL reset_miss_setup got no read request want one");
        end
        reset = 1; is_input_valid = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        vectors++;
        if (mem_req_valid !== 1'b0 || is_ready !== 1'b1 || is_output_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_miss got req=%b rdy=%b ov=%b want 0 1 0",
                     mem_req_valid, is_ready, is_output_valid);
        end
        for (int s = 0; s < 16; s++) begin
            if (ref_valid[s] && ref_dirty[s]) begin
                b = (32'(ref_tag[s]) << 8) | 32'(s << 4);
                for (int i = 0; i < LW; i++) shadow[b + 32'(4 * i)] = mem_rd(b + 32'(4 * i));
            end
            ref_valid[s] = 0; ref_dirty[s] = 0;
        end
        @(negedge clk);
        do_req(32'h100, 0, 0, 0, 0);
        vectors++;
        if (last_nrd != 1) begin
            miscompares++;
            $display("FAIL post_reset_miss got rd=%0d want 1", last_nrd);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int n = 0; n < 300; n++) begin
            a = {22'h0, 2'($urandom_range(3)), 4'($urandom_range(3)), 2'($urandom_range(3)), 2'b00};
            do_req(a, 1'($urandom_range(1)), $urandom, int'($urandom_range(3)), int'($urandom_range(3)));
        end
    endtask

    initial begin
        for (int s = 0; s < 16; s++) begin
            ref_valid[s] = 0; ref_dirty[s] = 0; ref_tag[s] = 0;
        end
        test_reset;
        test_cold_load;
        test_store_hit;
        test_dirty_evict;
        test_store_miss;
        test_ready_stall;
        test_reset_mid_miss;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and the multi-cycle data memory. It serves single-word loads and stores from the MEM stage, using a valid/ready handshake with a stall output. Misses run a line-refill finite state machine (FSM) that writes back dirty victims before allocating. The pipeline freezes while a request is outstanding and not yet answered.

## Interface
- LINE_WORDS, 4: 32-bit words per line (power of 2, ≥2).
- NUM_SETS, 16: number of lines (power of 2).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- is_input_valid  in  1  MEM stage presents a request.
- addr  in  32  byte address, word aligned (addr[1:0] ignored).
- mem_rw  in  1  0 = load, 1 = store.
- din  in  32  store data.
- is_ready  out  1  cache can accept a new request.
- is_output_valid  out  1  request completes this cycle.
- dout  out  32  load data, valid with is_output_valid.
- is_hit  out  1  current request hits (valid line, tag match).
- mem_req_valid  out  1  request to data memory.
- mem_req_write  out  1  1 = line writeback, 0 = line read.
- mem_req_addr  out  32  line-aligned byte address.
- mem_req_data  out  32*LINE_WORDS  writeback line; word 0 in bits [31:0].
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_resp_valid  in  1  read line returned this cycle.
- mem_resp_data  in  32*LINE_WORDS  returned line.

## Operation
- Address split: offset = addr[OB-1:2] with OB = 2+log2(LINE_WORDS); index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Per line: valid, dirty, tag, data. Data/tag arrays are flops; reads are combinational.
- FSM states: IDLE, WRITEBACK, ALLOC_REQ, ALLOC_WAIT.
- IDLE:
  - is_ready=1.
  - If is_input_valid and is_hit, then is_output_valid=1 combinationally.
  - Load hit: dout = selected word.
  - Store hit: write din into the word at the edge and set dirty.
  - If is_input_valid and miss, go to WRITEBACK when the victim is valid and dirty, else go to ALLOC_REQ.
- WRITEBACK:
  - mem_req_valid=1, mem_req_write=1.
  - mem_req_addr = {victim tag, index, 0}.
  - mem_req_data = victim line.
  - Hold until mem_req_ready, then go to ALLOC_REQ.
- ALLOC_REQ:
  - mem_req_valid=1, mem_req_write=0.
  - mem_req_addr = {request tag, index, 0}.
  - Hold until mem_req_ready, then go to ALLOC_WAIT.
- ALLOC_WAIT:
  - On mem_resp_valid, load the line and set valid=1, dirty=0, tag=request tag, then go to IDLE.
  - The held request then hits on re-evaluation; a store merges at that point and sets dirty.
- Outside IDLE: is_ready=0, is_output_valid=0, is_hit still reflects the array lookup.
- MEM stage stall = is_input_valid & ~is_output_valid.
- Requester holds addr/mem_rw/din stable until is_output_valid; changing them mid-miss is illegal and the result is undefined.
- mem_resp_valid outside ALLOC_WAIT is ignored. mem_req_ready outside WRITEBACK/ALLOC_REQ is ignored.
- dout = 0 when is_output_valid=0 or mem_rw=1.

## Timing
- Reset:
  - All valid and dirty bits cleared; data and tags are don't-care.
  - State IDLE.
  - Outputs: is_ready=1, is_output_valid=0, is_hit=0, dout=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_data=0.
- Hit latency: 0 extra cycles (completes in the presenting cycle).
- Clean miss: 1 (IDLE) + ALLOC_REQ cycles until ready + cycles until resp + 1 re-evaluation cycle in IDLE.
- Dirty miss: adds WRITEBACK cycles until ready.
- Minimum latencies, with ready and resp each arriving on the first cycle:
  - Clean miss: completes 3 cycles after presentation (IDLE, ALLOC_REQ, ALLOC_WAIT, IDLE-hit).
  - Dirty miss: 4 cycles.
- The request is held stable on mem_req_* from request assertion through the ready cycle.
- Reset mid-miss: abandon immediately, go to IDLE, clear all valid bits; the memory side is reset by the same reset.
- Same index, different tag: the victim is evicted. A line is never written back when dirty=0.

## Test plan
- Reset, then load 0x100 (cold miss; memory returns line 0x11,0x22,0x33,0x44 after 3 cycles):
  - exactly one read request at 0x100;
  - dout=0x11, is_hit=1 on completion;
  - loads 0x104/0x10C then hit in 0 cycles with 0x22/0x44.
- Store 0xDEADBEEF to 0x108 (hit), then load 0x108:
  - dout=0xDEADBEEF;
  - no memory request issued.
- Load 0x200 (same index 0, dirty victim):
  - writeback at 0x100 with data {0x44,0xDEADBEEF,0x22,0x11} (word 3..0);
  - then a read at 0x200.
- Store miss to 0x300 on a clean line: read at 0x300, merge din, dirty=1, no writeback.
- mem_req_ready held low 5 cycles: request fields stable throughout, is_ready=0, no completion.
- Assert reset in ALLOC_WAIT:
  - state IDLE and mem_req_valid=0 next cycle;
  - a subsequent load to 0x100 misses again.
